mips_loader: RTL

Hardware program loader and run controller for the MIPS32 datapath; it does the job the bench otherwise does through hierarchical writes. It accepts a program/data image over a valid/ready stream and writes it into datapath memory while holding the core in reset. On `start` it releases the core, waits for HALTED or a cycle timeout, reads one result register, and reports `done`. It sits between a host or debug port and the datapath's memory write port, reset/run controls and register read port.

---
 rtl/mips_loader_if.sv | 11 +
 rtl/mips_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mips_loader_if.sv
// Image stream from a host or debug port into mips_loader: one memory word per valid/ready beat.
interface mips_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_data;
  logic              in_last;

  modport master (output in_valid, in_addr, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_addr, in_data, in_last, output in_ready);
endinterface

// File: rtl/mips_loader.sv
// Program loader and run controller for the MIPS32 datapath: streams an image into memory,
// runs the core until HALTED or a cycle timeout, then captures one result register.
module mips_loader #(
  parameter int ADDR_W       = 10,
  parameter int RESULT_REG   = 2,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  mips_loader_if.slave      img,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              core_run,
  input  logic              core_halted,
  output logic [4:0]        reg_rd_addr,
  input  logic [31:0]       reg_rd_data,
  output logic [31:0]       result,
  output logic [31:0]       cycles,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int CLR_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, LOADED, CLEAR, RUN, CAPTURE, DONE, TIMEOUT} state_t;

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic             accept;
  logic             start_ok;

  assign reg_rd_addr = 5'(RESULT_REG);
  assign accept      = img.in_valid & img.in_ready;
  // An accepted beat takes priority over start, so start_ok is only consulted when no beat lands.
  assign start_ok    = start & (state inside {IDLE, LOADED, DONE, TIMEOUT});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      img.in_ready <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_reset   <= 1'b1;
      core_run     <= 1'b0;
      result       <= '0;
      cycles       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        mem_we     <= 1'b1;
        mem_addr   <= img.in_addr;
        mem_wdata  <= img.in_data;
        core_reset <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
        timeout    <= 1'b0;
        if (img.in_last) begin
          state        <= LOADED;
          img.in_ready <= 1'b0;
        end else begin
          state        <= LOAD;
          img.in_ready <= 1'b1;
        end
      end else if (start_ok) begin
        state        <= CLEAR;
        clr_cnt      <= '0;
        cycles       <= '0;
        img.in_ready <= 1'b0;
        core_reset   <= 1'b1;
        busy         <= 1'b1;
        done         <= 1'b0;
        timeout      <= 1'b0;
      end else begin
        case (state)
          IDLE: img.in_ready <= 1'b1;
          CLEAR: begin
            if (clr_cnt == CLR_W'(RESET_CYCLES - 1)) begin
              state      <= RUN;
              core_reset <= 1'b0;
              core_run   <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          RUN: begin
            cycles <= cycles + 32'd1;
            // Halt is tested first so a halt on the final allowed cycle still counts as done.
            if (core_halted) begin
              state    <= CAPTURE;
              core_run <= 1'b0;
            end else if (cycles == 32'(MAX_CYCLES - 1)) begin
              state        <= TIMEOUT;
              core_run     <= 1'b0;
              busy         <= 1'b0;
              timeout      <= 1'b1;
              img.in_ready <= 1'b1;
            end
          end
          CAPTURE: begin
            result       <= reg_rd_data;
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            img.in_ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
